// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle for the RV32I multi-cycle controller.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i;

  modport master (
    output imem_req_o, dmem_req_o, dmem_we_o,
    input  imem_ack_i, imem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  imem_req_o, dmem_req_o, dmem_we_o,
    output imem_ack_i, imem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath: sequences fetch/decode/exec/mem/wb,
// drives ALU op and mux selects, and arbitrates the shared imem/dmem handshakes.
module multicycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               res_i,
  multicycle_ctrl_if.master  bus,
  input  logic               branch_taken_i,
  output logic [31:0]        instr_o,
  output logic [3:0]         alu_ctrl_o,
  output logic [1:0]         src_a_sel_o,
  output logic               src_b_sel_o,
  output logic [1:0]         wb_sel_o,
  output logic [1:0]         pc_sel_o,
  output logic               pc_we_o,
  output logic               rf_we_o,
  output logic               retire_o,
  output logic [1:0]         trap_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam logic [8:0] TIMEOUT_LIM = 9'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  trap_q, trap_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       legal;
  logic       expire;
  logic [3:0] alu_op;
  logic [1:0] src_a;
  logic       src_b;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign f7b5      = ir_q[30];
  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign legal     = is_op | is_opimm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // The cycle that would take the wait count to the limit expires, unless ack arrives.
  assign expire = (({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM);

  always_comb begin
    alu_op = ALU_ADD;
    src_a  = 2'b00;
    src_b  = 1'b1;
    if (is_op || is_opimm) begin
      src_b = is_opimm;
      unique case (funct3)
        3'b000:  alu_op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (is_branch) begin
      src_b = 1'b0;
      unique case (funct3[2:1])
        2'b10:   alu_op = ALU_SLT;
        2'b11:   alu_op = ALU_SLTU;
        default: alu_op = ALU_SUB;
      endcase
    end else if (is_lui) begin
      src_a = 2'b10;
    end else if (is_auipc || is_jal) begin
      src_a = 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      state_q <= IDLE;
      ir_q    <= 32'h0000_0013;
      cnt_q   <= '0;
      trap_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  // cnt_d defaults to 0 so every state entry starts the wait count afresh.
  always_comb begin
    state_d        = state_q;
    ir_d           = ir_q;
    cnt_d          = '0;
    trap_d         = trap_q;
    bus.imem_req_o = 1'b0;
    bus.dmem_req_o = 1'b0;
    bus.dmem_we_o  = 1'b0;
    alu_ctrl_o     = '0;
    src_a_sel_o    = '0;
    src_b_sel_o    = 1'b0;
    wb_sel_o       = '0;
    pc_sel_o       = '0;
    pc_we_o        = 1'b0;
    rf_we_o        = 1'b0;
    retire_o       = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        bus.imem_req_o = 1'b1;
        if (bus.imem_ack_i) begin
          ir_d    = bus.imem_rdata_i;
          state_d = DECODE;
        end else if (expire) begin
          state_d = TRAP;
          trap_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          trap_d  = 2'b01;
        end
      end

      EXEC: begin
        alu_ctrl_o  = alu_op;
        src_a_sel_o = src_a;
        src_b_sel_o = src_b;
        if (is_branch) begin
          pc_sel_o = branch_taken_i ? 2'b01 : 2'b00;
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          state_d  = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        bus.dmem_req_o = 1'b1;
        bus.dmem_we_o  = is_store;
        alu_ctrl_o     = alu_op;
        src_a_sel_o    = src_a;
        src_b_sel_o    = src_b;
        if (bus.dmem_ack_i) begin
          if (is_store) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (expire) begin
          state_d = TRAP;
          trap_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      WB: begin
        alu_ctrl_o  = alu_op;
        src_a_sel_o = src_a;
        src_b_sel_o = src_b;
        rf_we_o     = (ir_q[11:7] != 5'd0);
        pc_we_o     = 1'b1;
        retire_o    = 1'b1;
        pc_sel_o    = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        wb_sel_o    = (is_jal || is_jalr) ? 2'b10 : (is_load ? 2'b01 : 2'b00);
        state_d     = FETCH;
      end

      default: state_d = TRAP;
    endcase
  end

  assign instr_o = ir_q;
  assign trap_o  = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with ACK_TIMEOUT=4; checks sampled 3 ns after
// each rising edge, inputs driven 2 ns after it.
module tb_multicycle_ctrl;
  logic        clk_i = 1'b0;
  logic        res_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] instr_o;
  logic [3:0]  alu_ctrl_o;
  logic [1:0]  src_a_sel_o;
  logic        src_b_sel_o;
  logic [1:0]  wb_sel_o;
  logic [1:0]  pc_sel_o;
  logic        pc_we_o;
  logic        rf_we_o;
  logic        retire_o;
  logic [1:0]  trap_o;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .res_i          (res_i),
    .bus            (bus),
    .branch_taken_i (branch_taken_i),
    .instr_o        (instr_o),
    .alu_ctrl_o     (alu_ctrl_o),
    .src_a_sel_o    (src_a_sel_o),
    .src_b_sel_o    (src_b_sel_o),
    .wb_sel_o       (wb_sel_o),
    .pc_sel_o       (pc_sel_o),
    .pc_we_o        (pc_we_o),
    .rf_we_o        (rf_we_o),
    .retire_o       (retire_o),
    .trap_o         (trap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called in FETCH: ack immediately with ins, leaves bench in DECODE.
  task automatic fetch(input logic [31:0] ins);
    bus.imem_ack_i   = 1'b1;
    bus.imem_rdata_i = ins;
    settle();
    chk("fetch_req", 32'(bus.imem_req_o), 32'd1);
    step();
    bus.imem_ack_i = 1'b0;
    settle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ir"}, instr_o, 32'h0000_0013);
    chk({tag, "_outs"}, 32'({bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, alu_ctrl_o,
        src_a_sel_o, src_b_sel_o, wb_sel_o, pc_sel_o, pc_we_o, rf_we_o, retire_o, trap_o}), 32'd0);
  endtask

  initial begin
    bus.imem_ack_i   = 1'b0;
    bus.imem_rdata_i = '0;
    bus.dmem_ack_i   = 1'b0;
    step();
    step();
    settle();
    chk_all_zero("reset");

    res_i = 1'b1;
    settle();
    chk("idle_req", 32'(bus.imem_req_o), 32'd0);
    step(); // FETCH
    fetch(32'h0020_81B3); // add x3,x1,x2
    chk("add_ir", instr_o, 32'h0020_81B3);
    chk("dec_req", 32'(bus.imem_req_o), 32'd0);
    step(); settle(); // EXEC
    chk("add_exec", 32'({alu_ctrl_o, src_b_sel_o, pc_we_o, rf_we_o, retire_o}), 32'h00);
    step(); settle(); // WB (cycle 4)
    chk("add_wb", 32'({rf_we_o, pc_we_o, retire_o, pc_sel_o, wb_sel_o}), 32'b1_1_1_00_00);
    step(); settle(); // FETCH
    chk("add_after", 32'({rf_we_o, pc_we_o, retire_o, bus.imem_req_o}), 32'b0001);

    fetch(32'h4020_81B3); // sub
    step(); settle();
    chk("sub_alu", 32'(alu_ctrl_o), 32'd1);
    step(); step(); settle();

    fetch(32'h0000_0013); // addi x0,x0,0
    step(); step(); settle();
    chk("x0_wb", 32'({rf_we_o, pc_we_o, retire_o}), 32'b011);
    step(); settle();

    fetch(32'h0020_8463); // beq taken
    branch_taken_i = 1'b1;
    step(); settle();
    chk("beq_t", 32'({alu_ctrl_o, pc_sel_o, pc_we_o, rf_we_o, retire_o}), 32'b0001_01_1_0_1);
    step(); settle();
    branch_taken_i = 1'b0;
    chk("beq_t_next", 32'({pc_we_o, retire_o, bus.imem_req_o}), 32'b001);

    fetch(32'h0020_8463); // beq not taken
    step(); settle();
    chk("beq_nt", 32'({pc_sel_o, pc_we_o, retire_o}), 32'b00_1_1);
    step(); settle();

    fetch(32'h0020_C463); // blt
    step(); settle();
    chk("blt_alu", 32'(alu_ctrl_o), 32'd5);
    step(); settle();

    fetch(32'h4030_D293); // srai x5,x1,3
    step(); settle();
    chk("srai", 32'({alu_ctrl_o, src_a_sel_o, src_b_sel_o}), 32'b1001_00_1);
    step(); step(); settle();

    fetch(32'h1234_52B7); // lui
    step(); settle();
    chk("lui", 32'({alu_ctrl_o, src_a_sel_o, src_b_sel_o}), 32'b0000_10_1);
    step(); step(); settle();

    fetch(32'h0100_00EF); // jal x1,16
    step(); settle();
    chk("jal_exec", 32'(src_a_sel_o), 32'd1);
    step(); settle();
    chk("jal_wb", 32'({pc_sel_o, wb_sel_o, rf_we_o}), 32'b01_10_1);
    step(); settle();

    fetch(32'h0001_00E7); // jalr x1,0(x2)
    step(); step(); settle();
    chk("jalr_wb", 32'({pc_sel_o, wb_sel_o, rf_we_o}), 32'b10_10_1);
    step(); settle();

    // lw x5: ack on 4th MEM cycle, the cycle the wait count hits ACK_TIMEOUT=4
    fetch(32'h0000_A283);
    step(); step(); settle(); // MEM
    for (int i = 0; i < 3; i++) begin
      chk("lw_req_wait", 32'({bus.dmem_req_o, bus.dmem_we_o, alu_ctrl_o}), 32'b1_0_0000);
      step(); settle();
    end
    bus.dmem_ack_i = 1'b1;
    settle();
    chk("lw_req_ack", 32'({bus.dmem_req_o, bus.dmem_we_o, retire_o}), 32'b100);
    step();
    bus.dmem_ack_i = 1'b0;
    settle();
    chk("lw_wb", 32'({bus.dmem_req_o, wb_sel_o, rf_we_o, retire_o, trap_o}), 32'b0_01_1_1_00);
    step(); settle();

    fetch(32'h0020_A023); // sw
    step(); step();
    bus.dmem_ack_i = 1'b1;
    settle();
    chk("sw_mem", 32'({bus.dmem_req_o, bus.dmem_we_o, pc_we_o, pc_sel_o, retire_o}), 32'b1_1_1_00_1);
    step();
    bus.dmem_ack_i = 1'b0;
    settle();
    chk("sw_next", 32'({bus.dmem_req_o, bus.imem_req_o, retire_o}), 32'b010);

    // reset mid-MEM, then a late ack
    fetch(32'h0000_A283);
    step(); step(); settle();
    chk("rst_mem_pre", 32'(bus.dmem_req_o), 32'd1);
    res_i = 1'b0;
    settle();
    chk_all_zero("rst_mem");
    bus.dmem_ack_i = 1'b1;
    step(); settle();
    chk_all_zero("rst_late_ack");
    res_i = 1'b1;
    settle();
    chk("rst_idle", 32'({bus.imem_req_o, bus.dmem_req_o}), 32'b00);
    step(); settle();
    chk("rst_fetch", 32'({bus.imem_req_o, bus.dmem_req_o, retire_o}), 32'b100);
    bus.dmem_ack_i = 1'b0;

    // illegal opcode
    fetch(32'h0000_007F);
    step(); settle();
    chk("ill_trap", 32'({trap_o, bus.imem_req_o}), 32'b01_0);
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("ill_hold", 32'({trap_o, bus.imem_req_o, pc_we_o, retire_o}), 32'b01_000);
    end

    // imem timeout
    res_i = 1'b0;
    step(); settle();
    chk("to_reset", 32'(trap_o), 32'd0);
    res_i = 1'b1;
    step(); settle();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'({bus.imem_req_o, trap_o}), 32'b1_00);
      step(); settle();
    end
    chk("to_trap", 32'({trap_o, bus.imem_req_o}), 32'b10_0);
    step(); settle();
    chk("to_hold", 32'({trap_o, bus.imem_req_o}), 32'b10_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
